// File: rtl/tcb_lib_arbiter.sv
// tcb_lib_arbiter
// Round-robin arbiter and select sequencer that shares one TCB manager port
// among SPN requesting ports. The request-phase grant is combinational. It is
// held (locked) while the shared port stalls. A response-phase select trails
// each transfer by the bus response delay DLY.
//
// Handshake: a transfer happens on every cycle where man_vld and rdy are both
// high. Once granted, a requester must keep vld asserted until its transfer
// completes. The lock keeps the grant on that requester regardless of the
// other vld lines.
module tcb_lib_arbiter #(
    parameter  int SPN = 2,
    parameter  int DLY = 1,
    localparam int SPL = $clog2(SPN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SPN-1:0] vld,
    input  logic           rdy,
    output logic [SPN-1:0] gnt,
    output logic [SPL-1:0] sel,
    output logic           man_vld,
    output logic           trn,
    output logic [SPL-1:0] rsp_sel,
    output logic           rsp_vld,
    output logic [SPL-1:0] dbg_ptr,
    output logic           dbg_lck,
    output logic [SPL-1:0] dbg_lck_idx
);

    // Round-robin start index and stall lock.
    logic [SPL-1:0] ptr_q;
    logic [SPL-1:0] ptr_d;
    logic           lck_q;
    logic           lck_d;
    logic [SPL-1:0] lck_idx_q;
    logic [SPL-1:0] lck_idx_d;

    // Port index increment that wraps at SPN rather than at 2^SPL.
    function automatic logic [SPL-1:0] wrap_inc(input logic [SPL-1:0] idx);
        if (idx == SPL'(SPN - 1)) begin
            return '0;
        end
        return idx + SPL'(1);
    endfunction

    // State register: arbitration pointer and lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            lck_q     <= 1'b0;
            lck_idx_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lck_q     <= lck_d;
            lck_idx_q <= lck_idx_d;
        end
    end

    // Output decode: locked grant, or the first requester at or after ptr.
    always_comb begin
        logic [SPL-1:0] idx;
        logic           found;
        gnt   = '0;
        sel   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        if (lck_q) begin
            sel            = lck_idx_q;
            gnt[lck_idx_q] = 1'b1;
        end else begin
            for (int i = 0; i < SPN; i++) begin
                if (!found && vld[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
                idx = wrap_inc(idx);
            end
            if (found) begin
                gnt[sel] = 1'b1;
            end
        end
    end

    // Only a granted requester that still asserts vld drives the shared port.
    assign man_vld = |(vld & gnt);
    assign trn     = man_vld & rdy;

    // Next state: a stall locks onto the granted port, and a transfer releases
    // the lock and rotates priority past the served port. A locked port that
    // drops vld leaves man_vld low, so the lock simply persists.
    always_comb begin
        ptr_d     = ptr_q;
        lck_d     = lck_q;
        lck_idx_d = lck_idx_q;
        if (man_vld && !rdy) begin
            lck_d     = 1'b1;
            lck_idx_d = sel;
        end else if (trn) begin
            lck_d = 1'b0;
        end
        if (trn) begin
            ptr_d = wrap_inc(sel);
        end
    end

    assign dbg_ptr     = ptr_q;
    assign dbg_lck     = lck_q;
    assign dbg_lck_idx = lck_idx_q;

    // Response-phase select: the request-phase select and transfer strobe
    // delayed by the shared port's response latency.
    generate
        if (DLY == 0) begin : g_rsp_comb
            assign rsp_sel = sel;
            assign rsp_vld = trn;
        end else begin : g_rsp_pipe
            logic [DLY-1:0] pipe_vld_q;
            logic [DLY-1:0] pipe_vld_d;
            logic [SPL-1:0] pipe_sel_q [DLY];
            logic [SPL-1:0] pipe_sel_d [DLY];

            // Shift stage: unconditional, so back-to-back transfers stay in order.
            always_comb begin
                pipe_vld_d[0] = trn;
                pipe_sel_d[0] = sel;
                for (int k = 1; k < DLY; k++) begin
                    pipe_vld_d[k] = pipe_vld_q[k-1];
                    pipe_sel_d[k] = pipe_sel_q[k-1];
                end
            end

            // Pipeline registers: reset drops every response in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld_q <= '0;
                    for (int k = 0; k < DLY; k++) begin
                        pipe_sel_q[k] <= '0;
                    end
                end else begin
                    pipe_vld_q <= pipe_vld_d;
                    for (int k = 0; k < DLY; k++) begin
                        pipe_sel_q[k] <= pipe_sel_d[k];
                    end
                end
            end

            // Outputs are held low during reset, so a response that was already
            // in the last stage when reset arrived is never signalled.
            assign rsp_vld = pipe_vld_q[DLY-1] & ~rst;
            assign rsp_sel = rst ? '0 : pipe_sel_q[DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Testbench for tcb_lib_arbiter: one instance with SPN=4/DLY=1 and one with
// SPN=3/DLY=2, checked cycle by cycle against a reference model, with
// responses scored through per-instance expected queues.
module tb_tcb_lib_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic [3:0] vld_a = '0;
    logic       rdy_a = 1'b1;
    logic [3:0] gnt_a;
    logic [1:0] sel_a, rsp_sel_a, ptr_a, lidx_a;
    logic       mv_a, trn_a, rsp_vld_a, lck_a;

    logic       rst_b = 1'b1;
    logic [2:0] vld_b = '0;
    logic       rdy_b = 1'b1;
    logic [2:0] gnt_b;
    logic [1:0] sel_b, rsp_sel_b, ptr_b, lidx_b;
    logic       mv_b, trn_b, rsp_vld_b, lck_b;

    tcb_lib_arbiter #(.SPN(4), .DLY(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .vld(vld_a), .rdy(rdy_a),
        .gnt(gnt_a), .sel(sel_a), .man_vld(mv_a), .trn(trn_a),
        .rsp_sel(rsp_sel_a), .rsp_vld(rsp_vld_a),
        .dbg_ptr(ptr_a), .dbg_lck(lck_a), .dbg_lck_idx(lidx_a)
    );

    tcb_lib_arbiter #(.SPN(3), .DLY(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .vld(vld_b), .rdy(rdy_b),
        .gnt(gnt_b), .sel(sel_b), .man_vld(mv_b), .trn(trn_b),
        .rsp_sel(rsp_sel_b), .rsp_vld(rsp_vld_b),
        .dbg_ptr(ptr_b), .dbg_lck(lck_b), .dbg_lck_idx(lidx_b)
    );

    // ---------------- scoreboard ----------------
    // Entry = {due cycle [31:8], expected rsp_sel [7:0]}.
    logic [31:0] exp_qa[$];
    logic [31:0] exp_qb[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state per instance (0 = A, 1 = B).
    int m_ptr[2]  = '{0, 0};
    int m_lck[2]  = '{0, 0};
    int m_lidx[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference arbitration: locked grant, else first vld scanning from ptr.
    function automatic void arb(input int spn, input int ptr, input int lck, input int lidx,
                                input logic [3:0] v, output int s, output logic [3:0] g);
        int j;
        s = ptr;
        g = '0;
        if (lck != 0) begin
            s       = lidx;
            g[lidx] = 1'b1;
        end else begin
            for (int i = 0; i < spn; i++) begin
                j = (ptr + i) % spn;
                if (v[j]) begin
                    s    = j;
                    g[j] = 1'b1;
                    break;
                end
            end
        end
    endfunction

    // ---------------- driver: one clock cycle on instance d ----------------
    task automatic cycle(input int d, input logic r, input logic [3:0] v, input logic rd);
        int          spn, dly, m_sel, due;
        logic [3:0]  m_gnt, o_gnt;
        logic        m_mv, m_trn;
        logic [1:0]  o_sel, o_rsel, o_ptr;
        logic        o_mv, o_trn, o_rvld, o_lck, due_now;
        logic [31:0] head;

        @(negedge clk);
        if (d == 0) begin
            rst_a = r; vld_a = v; rdy_a = rd;
        end else begin
            rst_b = r; vld_b = v[2:0]; rdy_b = rd;
        end
        #1;
        if (d == 0) begin
            o_gnt = gnt_a; o_sel = sel_a; o_mv = mv_a; o_trn = trn_a;
            o_rsel = rsp_sel_a; o_rvld = rsp_vld_a; o_ptr = ptr_a; o_lck = lck_a;
            spn = 4; dly = 1;
        end else begin
            o_gnt = {1'b0, gnt_b}; o_sel = sel_b; o_mv = mv_b; o_trn = trn_b;
            o_rsel = rsp_sel_b; o_rvld = rsp_vld_b; o_ptr = ptr_b; o_lck = lck_b;
            spn = 3; dly = 2;
        end

        arb(spn, m_ptr[d], m_lck[d], m_lidx[d], (d == 0) ? v : {1'b0, v[2:0]}, m_sel, m_gnt);
        m_mv  = |(v & m_gnt);
        m_trn = m_mv & rd;

        check("gnt", 32'(o_gnt), 32'(m_gnt));
        check("sel", 32'(o_sel), 32'(m_sel));
        check("man_vld", 32'(o_mv), 32'(m_mv));
        check("trn", 32'(o_trn), 32'(m_trn));
        check("ptr", 32'(o_ptr), 32'(m_ptr[d]));
        check("lck", 32'(o_lck), 32'(m_lck[d]));

        if (r) begin
            // Anything in flight is discarded by reset.
            if (d == 0) exp_qa.delete(); else exp_qb.delete();
            check("rsp_vld_rst", 32'(o_rvld), 32'd0);
            check("rsp_sel_rst", 32'(o_rsel), 32'd0);
        end else begin
            due_now = 1'b0;
            head    = '0;
            if (d == 0 && exp_qa.size() > 0 && exp_qa[0][31:8] == 24'(cyc)) begin
                head = exp_qa.pop_front(); due_now = 1'b1;
            end
            if (d == 1 && exp_qb.size() > 0 && exp_qb[0][31:8] == 24'(cyc)) begin
                head = exp_qb.pop_front(); due_now = 1'b1;
            end
            if (due_now) begin
                check("rsp_vld", 32'(o_rvld), 32'd1);
                check("rsp_sel", 32'(o_rsel), 32'(head[7:0]));
            end else begin
                check("rsp_vld_idle", 32'(o_rvld), 32'd0);
            end
            if (m_trn) begin
                due  = cyc + dly;
                head = {due[23:0], 8'(m_sel)};
                if (d == 0) exp_qa.push_back(head); else exp_qb.push_back(head);
            end
        end

        @(posedge clk);
        if (r) begin
            m_ptr[d] = 0; m_lck[d] = 0; m_lidx[d] = 0;
        end else begin
            if (m_mv && !rd) begin
                m_lck[d]  = 1;
                m_lidx[d] = m_sel;
            end else if (m_trn) begin
                m_lck[d] = 0;
            end
            if (m_trn) m_ptr[d] = (m_sel + 1) % spn;
        end
        cyc++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Instance A: SPN=4, DLY=1.
        repeat (2) cycle(0, 1'b1, 4'b1111, 1'b1);               // reset with all requesting
        repeat (8) cycle(0, 1'b0, 4'b1111, 1'b1);               // sel 0,1,2,3,0,1,2,3
        cycle(0, 1'b0, 4'b0010, 1'b0);                          // stall locks port 1
        cycle(0, 1'b0, 4'b0011, 1'b0);                          // port 0 rises, grant stays
        cycle(0, 1'b0, 4'b0011, 1'b0);
        cycle(0, 1'b0, 4'b0011, 1'b1);                          // transfer on port 1
        cycle(0, 1'b0, 4'b0011, 1'b1);                          // port 0 next
        cycle(0, 1'b0, 4'b1001, 1'b1);                          // ptr=1: sparse picks 3
        cycle(0, 1'b0, 4'b1001, 1'b1);                          // ptr wrapped to 0: picks 0
        cycle(0, 1'b0, 4'b0100, 1'b0);                          // lock on port 2
        cycle(0, 1'b0, 4'b0001, 1'b0);                          // locked port drops vld
        cycle(0, 1'b0, 4'b0001, 1'b1);                          // still locked, no transfer
        cycle(0, 1'b0, 4'b0100, 1'b1);                          // port 2 completes
        cycle(0, 1'b0, 4'b0001, 1'b1);                          // transfer at t
        cycle(0, 1'b1, 4'b0001, 1'b1);                          // reset at t+1
        cycle(0, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        repeat (3) cycle(0, 1'b0, 4'b0000, 1'b1);               // drain responses

        // Instance B: SPN=3, DLY=2.
        repeat (2) cycle(1, 1'b1, 4'b0111, 1'b1);
        repeat (7) cycle(1, 1'b0, 4'b0111, 1'b1);               // sel 0,1,2,0,...
        cycle(1, 1'b0, 4'b0000, 1'b1);
        cycle(1, 1'b0, 4'b0100, 1'b1);                          // ptr 2 -> 0 wrap
        cycle(1, 1'b0, 4'b0001, 1'b1);                          // transfer at t
        cycle(1, 1'b1, 4'b0000, 1'b1);                          // reset at t+1
        cycle(1, 1'b0, 4'b0000, 1'b1);                          // no response at t+2
        cycle(1, 1'b0, 4'b0010, 1'b0);                          // stall with DLY=2
        cycle(1, 1'b0, 4'b0011, 1'b0);
        cycle(1, 1'b0, 4'b0011, 1'b1);
        for (int i = 0; i < 60; i++) begin
            cycle(1, 1'b0, 4'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end
        repeat (4) cycle(1, 1'b0, 4'b0000, 1'b1);

        // Every expected response must have been delivered.
        check("qa_empty", 32'(exp_qa.size()), 32'd0);
        check("qb_empty", 32'(exp_qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tcb_lib_arbiter.md
# tcb_lib_arbiter

Round-robin arbiter and select sequencer for the TCB multiplexer, which shares one TCB manager port among SPN requesting managers. Each cycle it picks one requester from the per-port `vld` lines and drives the request-phase select. It holds that grant while a request stalls on `rdy`. It also produces a response-phase select delayed by the bus response latency DLY, so read data and status are steered back to the manager that issued the transfer.

## Interface
- `SPN`, default 2: number of requesting (subordinate-side) ports, ≥2; need not be a power of 2.
- `SPL`, default $clog2(SPN): localparam, select width.
- `DLY`, default 1: TCB response delay in cycles (PHY.DLY of the shared port), ≥0.
- `clk`, input, 1: clock, single domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `vld`, input, SPN: request valid from each requesting port.
- `rdy`, input, 1: ready from the shared manager port.
- `gnt`, output, SPN: one-hot request grant; all-zero when no request.
- `sel`, output, SPL: binary index of the granted port (request-phase mux select).
- `man_vld`, output, 1: valid to the shared port, equal to `|(vld & gnt)`.
- `trn`, output, 1: transfer strobe, `man_vld & rdy`.
- `rsp_sel`, output, SPL: response-phase mux select, equal to `sel` delayed by DLY cycles.
- `rsp_vld`, output, 1: `trn` delayed by DLY cycles; marks the cycle the response is valid.

## Operation
- State:
  - `ptr` [SPL-1:0]: round-robin start index.
  - `lck` (1 bit) and `lck_idx` [SPL-1:0]: stall lock.
  - DLY-deep pipeline of {trn, sel}.
- Arbitration (combinational) when `lck`=0:
  - Scan indices ptr, ptr+1, …, SPN-1, 0, …, ptr-1. The first index with `vld`=1 wins.
  - Index wrap is modulo SPN, not 2^SPL.
  - If no `vld` is set: `gnt`=0, `sel`=`ptr`, `man_vld`=0.
- Lock: when `lck`=1, `gnt`=onehot(`lck_idx`) and `sel`=`lck_idx`, regardless of the other `vld` lines.
- Lock update, registered:
  - `man_vld & ~rdy` sets `lck`=1 and `lck_idx`=`sel`.
  - `trn` clears `lck`.
  - A locked requester that drops `vld` is a protocol violation. In that case the lock still holds until that port's next transfer, and `man_vld`=0 meanwhile.
- Pointer update: on `trn`, `ptr` <= (`sel`+1) mod SPN. Otherwise `ptr` holds. Only completed transfers rotate priority.
- Response pipeline:
  - DLY=0: `rsp_sel`=`sel` and `rsp_vld`=`trn`, both combinational.
  - DLY≥1: stage0 <= {`trn`, `sel`} every cycle, and stage k <= stage k-1. Outputs come from stage DLY-1.
  - The pipeline shifts unconditionally. Back-to-back transfers to different ports therefore return responses back-to-back with the correct selects.
- Reset (`rst`=1 at a `clk` edge): `ptr`=0, `lck`=0, `lck_idx`=0, all pipeline stages={0,0}.
  - While `rst`=1 the registered outputs `rsp_vld`=0 and `rsp_sel`=0. Combinational outputs still follow `vld` with `ptr`=0.
  - Responses in flight at reset are discarded; `rsp_vld` is never asserted for them.

## Timing
- Request grant: 0-cycle latency. `gnt`, `sel` and `man_vld` are combinational from `vld`, `ptr` and the lock.
- `rsp_vld` and `rsp_sel` follow the corresponding `trn` by exactly DLY cycles.
- Fairness: a continuously requesting port is granted within SPN transfers.
- Simultaneous set/clear of the lock cannot occur, because `trn` and `~rdy` are exclusive.
- A `rdy` stall lasting N cycles holds the same `gnt` for N+1 cycles, with `ptr` unchanged until the transfer.
- SPN non-power-of-2, e.g. 3: `ptr`=2, `trn` on port 2 → `ptr`=0, never 3.

## Test plan
- Reset: assert `rst` 2 cycles with `vld`=4'b1111 (SPN=4, DLY=1) → `ptr`=0, `gnt`=4'b0001, `rsp_vld`=0 throughout; after release, first `trn` grants port 0.
- Round-robin with `vld`=4'b1111 and `rdy`=1 for 8 cycles → `sel` sequence 0,1,2,3,0,1,2,3; `rsp_sel` is the same sequence lagging 1 cycle; `rsp_vld`=1 from cycle 2.
- Stall lock: `vld`=4'b0010 with `rdy`=0 for 3 cycles, `vld[0]` rising in cycle 2, then `rdy`=1 → `gnt`=4'b0010 for all 4 cycles; one `trn` on port 1; `ptr`=2 afterwards; port 0 is granted next.
- Sparse requests: `vld`=4'b1001, `ptr`=1 → `sel`=3; after `trn`, `ptr`=0, next `sel`=0.
- SPN=3, DLY=2: `vld`=3'b111 with `rdy`=1 → `sel` 0,1,2,0; `rsp_sel` is the same sequence lagging 2 cycles; `rsp_sel` never equals 3.
- Reset mid-flight, DLY=2: `trn` in cycle t, `rst` in cycle t+1 → `rsp_vld`=0 at t+2; `ptr`=0 and `lck`=0 after reset.
